// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async FIFO: binary/Gray conversion on a wide carrier word.
// Callers widen their pointer into ptr_word_t and cast the result back to their own width.
package fifo_ptr_pkg;

    localparam int unsigned PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    // Zero-extended inputs stay valid: the upper zero bits convert to zero.
    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin = '0;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = int'(PTR_MAX_W) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/counter_bingray.sv
// Binary counter with a registered Gray copy; the Gray register changes one bit per increment.
module counter_bingray
    import fifo_ptr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    output logic [WIDTH-1:0] ow_counter_bin_next,
    output logic [WIDTH-1:0] o_counter_bin,
    output logic [WIDTH-1:0] o_counter_gray
);

    assign ow_counter_bin_next = o_counter_bin + WIDTH'(i_enable);

    // Gray is encoded from the next binary value so both registers update on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_counter_bin  <= '0;
            o_counter_gray <= '0;
        end else begin
            o_counter_bin  <= ow_counter_bin_next;
            o_counter_gray <= WIDTH'(bin2gray(PTR_MAX_W'(ow_counter_bin_next)));
        end
    end

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer controller for the async FIFO: accepts pushes, advances the write
// pointer, synchronizes the remote read Gray pointer and registers full/almost-full/count.
module fifo_wr_ptr_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter  int unsigned DEPTH       = 8,
    parameter  int unsigned N_FLOP_SYNC = 2,
    parameter  int unsigned ALMOST_FULL = 6,
    localparam int unsigned AW          = $clog2(DEPTH),
    localparam int unsigned PW          = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [PW-1:0] o_wr_ptr_gray,
    input  logic [PW-1:0] i_rd_ptr_gray_async,
    output logic          o_full,
    output logic          o_almost_full,
    output logic [PW-1:0] o_count
);

    // Full when the next write pointer is exactly DEPTH ahead: top two Gray bits inverted.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("DEPTH must be a power of 2 and at least 2");
        end
        if (N_FLOP_SYNC < 2) begin : g_bad_sync
            $error("N_FLOP_SYNC must be at least 2");
        end
        if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_bad_afull
            $error("ALMOST_FULL must lie in 1..DEPTH");
        end
    endgenerate

    logic [PW-1:0] wr_bin;
    logic [PW-1:0] wnext_bin;
    logic [PW-1:0] wnext_gray;
    logic [PW-1:0] sync_q [N_FLOP_SYNC];
    logic [PW-1:0] rq_gray;
    logic [PW-1:0] rq_bin;
    logic          full_n;
    logic          afull_n;
    logic [PW-1:0] count_n;

    assign o_wr_en    = i_wr_valid & ~o_full;
    assign o_wr_ready = ~o_full;
    assign o_wr_addr  = AW'(wr_bin);

    counter_bingray #(
        .WIDTH (PW)
    ) u_wr_ptr (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_enable            (o_wr_en),
        .ow_counter_bin_next (wnext_bin),
        .o_counter_bin       (wr_bin),
        .o_counter_gray      (o_wr_ptr_gray)
    );

    // Read-pointer synchronizer; the first stage may go metastable, later stages filter it.
    generate
        for (genvar g = 0; g < int'(N_FLOP_SYNC); g++) begin : g_sync
            if (g == 0) begin : g_first
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        sync_q[g] <= '0;
                    end else begin
                        sync_q[g] <= i_rd_ptr_gray_async;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        sync_q[g] <= '0;
                    end else begin
                        sync_q[g] <= sync_q[g-1];
                    end
                end
            end
        end
    endgenerate

    assign rq_gray = sync_q[N_FLOP_SYNC-1];
    assign rq_bin  = PW'(gray2bin(PTR_MAX_W'(rq_gray)));

    // Flags use the post-push pointer against a stale read pointer, so they err toward full.
    always_comb begin
        wnext_gray = PW'(bin2gray(PTR_MAX_W'(wnext_bin)));
        full_n     = (wnext_gray == (rq_gray ^ FULL_MASK));
        count_n    = wnext_bin - rq_bin;
        afull_n    = (count_n >= PW'(ALMOST_FULL));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_full        <= 1'b0;
            o_almost_full <= 1'b0;
            o_count       <= '0;
        end else begin
            o_full        <= full_n;
            o_almost_full <= afull_n;
            o_count       <= count_n;
        end
    end

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Bench for fifo_wr_ptr_ctrl (DEPTH=8, ALMOST_FULL=6, N_FLOP_SYNC=2) against a
// pointer-total model whose read view lags the driven read pointer by the sync depth.
module tb_fifo_wr_ptr_ctrl;

    localparam int DEPTH  = 8;
    localparam int AFULL  = 6;
    localparam int NSYNC  = 2;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_wr_valid;
    logic       o_wr_ready;
    logic       o_wr_en;
    logic [2:0] o_wr_addr;
    logic [3:0] o_wr_ptr_gray;
    logic [3:0] i_rd_ptr_gray_async;
    logic       o_full;
    logic       o_almost_full;
    logic [3:0] o_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: unbounded pointer totals and the read values still in flight.
    int wr_total;
    int rd_in_flight[$];
    int m_count;
    bit m_full;
    bit m_afull;
    bit exp_wr_en;
    int exp_addr;
    logic       obs_wr_en;
    logic [2:0] obs_addr;
    logic [3:0] gm_prev;

    fifo_wr_ptr_ctrl #(
        .DEPTH       (DEPTH),
        .N_FLOP_SYNC (NSYNC),
        .ALMOST_FULL (AFULL)
    ) dut (
        .i_clk               (i_clk),
        .i_rst_n             (i_rst_n),
        .i_wr_valid          (i_wr_valid),
        .o_wr_ready          (o_wr_ready),
        .o_wr_en             (o_wr_en),
        .o_wr_addr           (o_wr_addr),
        .o_wr_ptr_gray       (o_wr_ptr_gray),
        .i_rd_ptr_gray_async (i_rd_ptr_gray_async),
        .o_full              (o_full),
        .o_almost_full       (o_almost_full),
        .o_count             (o_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [3:0] g4(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic model_reset();
        wr_total = 0;
        rd_in_flight = '{0, 0};
        m_count = 0;
        m_full  = 1'b0;
        m_afull = 1'b0;
    endtask

    // One clock: drive inputs, capture combinational outputs, clock, advance the model.
    task automatic step(input bit v, input int rd);
        int rq;
        i_wr_valid = v;
        i_rd_ptr_gray_async = g4(rd);
        #1;
        exp_wr_en = v && !m_full;
        exp_addr  = wr_total % DEPTH;
        obs_wr_en = o_wr_en;
        obs_addr  = o_wr_addr;
        @(posedge i_clk);
        #1;
        if (exp_wr_en) wr_total++;
        rq = rd_in_flight.pop_front();
        rd_in_flight.push_back(rd);
        m_count = (wr_total - rq) % 16;
        m_full  = (m_count == DEPTH);
        m_afull = (m_count >= AFULL);
    endtask

    // Gray pointer may change by at most one bit between samples outside reset.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            gm_prev = 4'b0;
        end else begin
            n_tests++;
            if ($countones(o_wr_ptr_gray ^ gm_prev) > 1) begin
                n_fail++;
                $display("FAIL gray_hamming: prev=%b now=%b", gm_prev, o_wr_ptr_gray);
            end
            gm_prev = o_wr_ptr_gray;
        end
    end

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_wr_valid = 1'b0;
        i_rd_ptr_gray_async = 4'b0;
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        n_tests++;
        if ({o_count, o_full, o_almost_full, o_wr_ptr_gray, o_wr_addr, o_wr_en} !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: count=%h full=%b afull=%b gray=%h addr=%h en=%b want all 0",
                     o_count, o_full, o_almost_full, o_wr_ptr_gray, o_wr_addr, o_wr_en);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        n_tests++;
        if (o_wr_ready !== 1'b1 || o_count !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b count=%0d want ready=1 count=0", o_wr_ready, o_count);
        end
    endtask

    task automatic test_fill();
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 0);
            n_tests++;
            if (obs_wr_en !== exp_wr_en || obs_addr !== 3'(exp_addr)) begin
                n_fail++;
                $display("FAIL fill_accept k=%0d: en=%b addr=%0d want en=%b addr=%0d",
                         k, obs_wr_en, obs_addr, exp_wr_en, exp_addr);
            end
            n_tests++;
            if ({o_count, o_full, o_almost_full, o_wr_ready, o_wr_ptr_gray} !==
                {4'(m_count), m_full, m_afull, !m_full, g4(wr_total)}) begin
                n_fail++;
                $display("FAIL fill_flags k=%0d: count=%0d full=%b afull=%b gray=%b want %0d %b %b %b",
                         k, o_count, o_full, o_almost_full, o_wr_ptr_gray, m_count, m_full, m_afull, g4(wr_total));
            end
            n_tests++;
            if ((k == 6 && o_almost_full !== 1'b1) || (k == 5 && o_almost_full !== 1'b0) ||
                (k == 7 && o_full !== 1'b0) || (k >= 8 && (o_full !== 1'b1 || o_count !== 4'd8))) begin
                n_fail++;
                $display("FAIL fill_boundary k=%0d: full=%b afull=%b count=%0d", k, o_full, o_almost_full, o_count);
            end
        end
        n_tests++;
        if (obs_wr_en !== 1'b0 || obs_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL fill_overflow_drop: en=%b addr=%0d want en=0 addr=0", obs_wr_en, obs_addr);
        end
    endtask

    task automatic test_drain_release();
        for (int e = 1; e <= 3; e++) begin
            step(1'b0, 4);
            n_tests++;
            if (e < 3 && (o_full !== 1'b1 || o_count !== 4'd8)) begin
                n_fail++;
                $display("FAIL drain_early e=%0d: full=%b count=%0d want full=1 count=8", e, o_full, o_count);
            end else if (e == 3 && (o_full !== 1'b0 || o_count !== 4'd4 || o_almost_full !== 1'b0)) begin
                n_fail++;
                $display("FAIL drain_release: full=%b count=%0d afull=%b want 0 4 0", o_full, o_count, o_almost_full);
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int k = 0; k < 4; k++) step(1'b1, 4);
        n_tests++;
        if (o_full !== 1'b1 || o_count !== 4'd8) begin
            n_fail++;
            $display("FAIL simul_refill: full=%b count=%0d want full=1 count=8", o_full, o_count);
        end
        for (int e = 1; e <= 4; e++) begin
            step(1'b1, 5);
            n_tests++;
            if (obs_wr_en !== (e == 4) || obs_wr_en !== exp_wr_en) begin
                n_fail++;
                $display("FAIL simul_accept e=%0d: en=%b want %b", e, obs_wr_en, (e == 4));
            end
            n_tests++;
            if ({o_count, o_full} !== {4'(m_count), m_full}) begin
                n_fail++;
                $display("FAIL simul_flags e=%0d: count=%0d full=%b want %0d %b", e, o_count, o_full, m_count, m_full);
            end
        end
        n_tests++;
        if (o_full !== 1'b1 || o_count !== 4'd8) begin
            n_fail++;
            $display("FAIL simul_refull: full=%b count=%0d want full=1 count=8", o_full, o_count);
        end
    endtask

    task automatic test_reset_midop();
        for (int e = 0; e < 3; e++) step(1'b0, 8);
        n_tests++;
        if (o_count !== 4'd5 || m_count != 5) begin
            n_fail++;
            $display("FAIL midop_pre_count: count=%0d model=%0d want 5", o_count, m_count);
        end
        i_wr_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        i_rd_ptr_gray_async = 4'b0;
        #1;
        n_tests++;
        if ({o_count, o_full, o_almost_full, o_wr_ptr_gray, o_wr_addr, o_wr_en} !== 14'b0) begin
            n_fail++;
            $display("FAIL midop_reset_now: count=%h full=%b afull=%b gray=%h addr=%h en=%b want all 0",
                     o_count, o_full, o_almost_full, o_wr_ptr_gray, o_wr_addr, o_wr_en);
        end
        model_reset();
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step(1'b1, 0);
        n_tests++;
        if (obs_wr_en !== 1'b1 || obs_addr !== 3'd0 || o_wr_ptr_gray !== 4'b0001) begin
            n_fail++;
            $display("FAIL midop_first_push: en=%b addr=%0d gray=%b want 1 0 0001", obs_wr_en, obs_addr, o_wr_ptr_gray);
        end
    endtask

    task automatic test_wrap();
        int  rd;
        bit  any_full;
        bit  saw_wrap;
        logic [3:0] g_before;
        any_full = 1'b0;
        saw_wrap = 1'b0;
        while (wr_total < 21) begin
            rd = (wr_total >= 2) ? wr_total - 2 : 0;
            g_before = o_wr_ptr_gray;
            step(1'b1, rd);
            any_full |= o_full;
            if (wr_total == 16 && g_before === 4'b1000 && o_wr_ptr_gray === 4'b0000) saw_wrap = 1'b1;
            rd = (wr_total >= 2) ? wr_total - 2 : 0;
            for (int e = 0; e < 3; e++) begin
                step(1'b0, rd);
                any_full |= o_full;
            end
            n_tests++;
            if ({o_count, o_wr_ptr_gray} !== {4'(m_count), g4(wr_total)} ||
                (wr_total >= 2 && o_count !== 4'd2)) begin
                n_fail++;
                $display("FAIL wrap_steady wr=%0d: count=%0d gray=%b want %0d %b",
                         wr_total, o_count, o_wr_ptr_gray, m_count, g4(wr_total));
            end
        end
        n_tests++;
        if (any_full || !saw_wrap) begin
            n_fail++;
            $display("FAIL wrap_summary: any_full=%b saw_wrap=%b want 0 1", any_full, saw_wrap);
        end
    endtask

    task automatic test_random();
        int rd_total;
        int room;
        rd_total = wr_total - 2;
        for (int c = 0; c < 400; c++) begin
            room = wr_total - rd_total;
            if (room > 0 && $urandom_range(0, 2) == 0)
                rd_total += $urandom_range(1, (room < 3) ? room : 3);
            step($urandom_range(0, 9) < 7, rd_total);
            n_tests++;
            if (obs_wr_en !== exp_wr_en || obs_addr !== 3'(exp_addr) ||
                {o_count, o_full, o_almost_full, o_wr_ready, o_wr_ptr_gray} !==
                {4'(m_count), m_full, m_afull, !m_full, g4(wr_total)}) begin
                n_fail++;
                $display("FAIL random c=%0d: en=%b addr=%0d count=%0d full=%b afull=%b gray=%b want %b %0d %0d %b %b %b",
                         c, obs_wr_en, obs_addr, o_count, o_full, o_almost_full, o_wr_ptr_gray,
                         exp_wr_en, exp_addr, m_count, m_full, m_afull, g4(wr_total));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain_release();
        test_simultaneous();
        test_reset_midop();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
